// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receiver.
package uart_pkg;
  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_e;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int CNT_W = $clog2(OVERSAMPLE_DEF);

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/uart_rx_os_if.sv
// Output handshake of the receiver: held frame plus flags, consumer ready.
interface uart_rx_os_if #(parameter int DATA_BITS = 8);
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  modport master(output data, valid, parity_err, frame_err, overrun, input ready);
  modport slave (input data, valid, parity_err, frame_err, overrun, output ready);
endinterface

// File: rtl/uart_rx_sampler.sv
// rx synchroniser plus 3-point majority vote around the bit centre.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter  int OVERSAMPLE  = 16,
  parameter  int SYNC_STAGES = 2,
  localparam int CW          = $clog2(OVERSAMPLE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic          rx,
  input  logic [CW-1:0] cnt,
  output logic          rx_s,
  output logic          bit_val,
  output logic          bit_stb
);
  localparam int M = OVERSAMPLE / 2;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [1:0]             smp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      smp_q  <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      if (tick && cnt == CW'(M-1)) smp_q[0] <= rx_s;
      if (tick && cnt == CW'(M))   smp_q[1] <= rx_s;
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];
  // third vote is the live sample on the decision tick itself
  assign bit_stb = tick && (cnt == CW'(M+1));
  assign bit_val = maj3(smp_q[0], smp_q[1], rx_s);
endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: frame FSM, shift/parity tracking, 1-entry output buffer.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         tick,
  input  logic         rx,
  output logic         busy,
  uart_rx_os_if.master rx_if
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_MAX  = CW'(OVERSAMPLE-1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS-1);

  rx_state_e            state_q;
  logic [CW-1:0]        cnt_q;
  logic [BW-1:0]        bit_q;
  logic                 stop_q, par_q, perr_q, ferr_q, busy_q;
  logic [DATA_BITS-1:0] shift_q, data_q;
  logic                 valid_q, out_perr_q, out_ferr_q, ovr_q;
  logic                 rx_s, bit_val, bit_stb, last_stop, frame_done, pop;

  uart_rx_sampler #(.OVERSAMPLE(OVERSAMPLE), .SYNC_STAGES(SYNC_STAGES)) u_smp (
    .clk(clk), .rst_n(rst_n), .tick(tick), .rx(rx), .cnt(cnt_q),
    .rx_s(rx_s), .bit_val(bit_val), .bit_stb(bit_stb)
  );

  assign last_stop  = (STOP_BITS == 1) || stop_q;
  assign frame_done = en && bit_stb && (state_q == STOP) && last_stop;
  assign pop        = valid_q && rx_if.ready;

  // The counter free-runs through the frame, so moving to the next state at the
  // decision tick still lands the next decision in the following bit period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else if (!en) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else if (state_q == IDLE) begin
      if (tick && !rx_s) begin
        state_q <= START;
        cnt_q   <= '0;
        busy_q  <= 1'b1;
      end
    end else begin
      if (tick) cnt_q <= (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
      if (bit_stb) begin
        unique case (state_q)
          START: begin
            if (bit_val) begin
              state_q <= IDLE;
              cnt_q   <= '0;
              busy_q  <= 1'b0;
            end else begin
              state_q <= DATA;
              bit_q   <= '0;
              par_q   <= 1'b0;
              perr_q  <= 1'b0;
              ferr_q  <= 1'b0;
              stop_q  <= 1'b0;
            end
          end
          DATA: begin
            shift_q <= {bit_val, shift_q[DATA_BITS-1:1]};
            par_q   <= par_q ^ bit_val;
            bit_q   <= bit_q + 1'b1;
            if (bit_q == BIT_LAST) state_q <= (PARITY != 0) ? uart_pkg::PARITY : STOP;
          end
          uart_pkg::PARITY: begin
            perr_q  <= par_q ^ bit_val ^ (PARITY == 2);
            state_q <= STOP;
          end
          STOP: begin
            ferr_q <= ferr_q | ~bit_val;
            stop_q <= 1'b1;
            if (last_stop) begin
              state_q <= IDLE;
              cnt_q   <= '0;
              busy_q  <= 1'b0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q     <= '0;
      valid_q    <= 1'b0;
      out_perr_q <= 1'b0;
      out_ferr_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      ovr_q <= frame_done && valid_q && !pop;
      if (frame_done && (!valid_q || pop)) begin
        data_q     <= shift_q;
        out_perr_q <= perr_q;
        out_ferr_q <= ferr_q | ~bit_val;
        valid_q    <= 1'b1;
      end else if (pop) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx_if.data       = data_q;
  assign rx_if.valid      = valid_q;
  assign rx_if.parity_err = out_perr_q;
  assign rx_if.frame_err  = out_ferr_q;
  assign rx_if.overrun    = ovr_q;
  assign busy             = busy_q;
endmodule
